control_unit: RTL

Hardwired Moore controller for the single-bus datapath. It steps a T-state sequence (fetch T0–T2, execute T3–T7) and drives every bus-out, register-in, memory and ALU select line the datapath consumes. It sits directly upstream of the datapath: it decodes the datapath's IR and sequences the control signals that a bench would otherwise drive by hand. Memory accesses stall on a completion handshake.

---
 rtl/control_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit
//  Purpose  : Hardwired Moore sequencer (fetch T0-T2, execute T3-T7) driving
//             the single-bus datapath strobes, with memory-handshake stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_done,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic [3:0]  alu_op,
    output logic        run
);

    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [4:0] opcode;
    logic [4:0] alu_sel;
    logic       is_ld;
    logic       is_ldi;
    logic       is_st;
    logic       is_alu;
    logic       is_imm;
    logic       is_halt;
    logic       unused_ir_bits;

    assign opcode         = ir[31:27];
    assign unused_ir_bits = ^ir[26:0];

    assign is_ld   = (opcode == OP_LD);
    assign is_ldi  = (opcode == OP_LDI);
    assign is_st   = (opcode == OP_ST);
    assign is_alu  = (opcode >= 5'd3) && (opcode <= 5'd10);
    assign is_imm  = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
    assign is_halt = (opcode == OP_HALT);

    // Reg-reg opcodes add..rol (3..10) map linearly onto ALU codes 1..8.
    assign alu_sel = opcode - 5'd2;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = mem_done ? S_T2 : S_T1;
            S_T2: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_ld || is_ldi || is_st || is_alu || is_imm) begin
                    state_d = S_T3;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T3:   state_d = S_T4;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (is_ld || is_st) ? S_T6 : S_T0;
            S_T6:   state_d = (is_ld && !mem_done) ? S_T6 : S_T7;
            S_T7:   state_d = (is_st && !mem_done) ? S_T7 : S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        BAout   = 1'b0;
        Cout    = 1'b0;
        alu_op  = 4'b0000;
        run     = (state_q != S_RST) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Grb   = 1'b1;
                Yin   = 1'b1;
                Rout  = is_alu || is_imm;
                BAout = is_ld || is_ldi || is_st;
            end
            S_T4: begin
                Zin = 1'b1;
                if (is_alu) begin
                    Grc    = 1'b1;
                    Rout   = 1'b1;
                    alu_op = alu_sel[3:0];
                end else begin
                    Cout = 1'b1;
                    case (opcode)
                        OP_ANDI: alu_op = ALU_AND;
                        OP_ORI:  alu_op = ALU_OR;
                        default: alu_op = ALU_ADD;
                    endcase
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_ld || is_st) begin
                    MARin = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
            end
            S_T6: begin
                MDRin = 1'b1;
                if (is_ld) begin
                    Read = 1'b1;
                end else begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end else begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
